// File: rtl/uart_mem_loader_pkg.sv
// uart_mem_loader_pkg: shared state encodings and packet constants
package uart_mem_loader_pkg;
  typedef enum logic [2:0] {WAIT_SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CHECK} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-FF synchronizer and mid-bit sampling
module uart_rx_byte
  import uart_mem_loader_pkg::*;
#(
  parameter int DIV = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  // sync[1] is the synchronized line, sync[2] its previous value for edge detect
  logic [2:0] sync;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bits;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync <= '1;
      state <= RX_IDLE;
      cnt <= '0;
      bits <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[1:0], rx};
      valid <= 1'b0;
      frame_err <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (sync[2] && !sync[1]) state <= RX_START;
        end
        RX_START:
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            bits <= '0;
            state <= sync[1] ? RX_IDLE : RX_DATA;
          end
        RX_DATA:
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            data <= {sync[1], data[7:1]};
            bits <= bits + 1'b1;
            if (bits == 3'd7) state <= RX_STOP;
          end
        default:
          if (cnt == BIT_LAST) begin
            state <= RX_IDLE;
            valid <= sync[1];
            frame_err <= !sync[1];
          end
      endcase
    end
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: parses framed UART packets and writes their payload into RAM
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int         CLK_HZ  = 25000000,
  parameter int         BAUD    = 115200,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] address,
  output logic [7:0]  out,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  logic [7:0] rx_data;
  logic rx_valid, rx_ferr;
  state_t state;
  logic [15:0] base, len, idx;
  logic [7:0] sum;
  logic [TW-1:0] tcnt;
  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clock(clock), .reset(reset), .rx(rx),
    .data(rx_data), .valid(rx_valid), .frame_err(rx_ferr)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= WAIT_SYNC;
      address <= '0;
      out <= '0;
      we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      base <= '0;
      len <= '0;
      idx <= '0;
      sum <= '0;
      tcnt <= '0;
    end else begin
      we <= 1'b0;
      done <= 1'b0;
      tcnt <= (rx_valid || !busy) ? '0 : tcnt + 1'b1;
      if (rx_ferr) begin
        error <= 1'b1;
        busy <= 1'b0;
        state <= WAIT_SYNC;
      end else if (rx_valid) begin
        case (state)
          WAIT_SYNC:
            if (rx_data == SYNC) begin
              state <= ADDR_H;
              busy <= 1'b1;
              error <= 1'b0;
              sum <= '0;
            end
          ADDR_H: begin base[15:8] <= rx_data; state <= ADDR_L; end
          ADDR_L: begin base[7:0] <= rx_data; state <= LEN_H; end
          LEN_H: begin len[15:8] <= rx_data; state <= LEN_L; end
          LEN_L: begin
            len[7:0] <= rx_data;
            idx <= '0;
            state <= ({len[15:8], rx_data} == 16'd0) ? CHECK : DATA;
          end
          DATA: begin
            address <= base + idx;
            out <= rx_data;
            we <= 1'b1;
            sum <= sum ^ rx_data;
            idx <= idx + 16'd1;
            if (idx + 16'd1 == len) state <= CHECK;
          end
          default: begin
            done <= (rx_data == sum);
            if (rx_data != sum) error <= 1'b1;
            busy <= 1'b0;
            state <= WAIT_SYNC;
          end
        endcase
      end else if (busy && tcnt == T_LAST) begin
        error <= 1'b1;
        busy <= 1'b0;
        state <= WAIT_SYNC;
      end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: table-driven packet vectors plus glitch, timeout and reset sequences
module tb_uart_mem_loader;
  localparam int DIV = 16;
  localparam int TIMEOUT = 3000;
  logic clock = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [15:0] address;
  logic [7:0] out;
  logic we, busy, done, error;
  int total = 0, passed = 0, done_cnt = 0, we_idle = 0;
  logic [15:0] wa_q[$];
  logic [7:0] wd_q[$];

  uart_mem_loader #(.CLK_HZ(25000000), .BAUD(1562500), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .rx(rx), .address(address), .out(out),
    .we(we), .busy(busy), .done(done), .error(error)
  );

  always #20 clock = ~clock;

  always @(negedge clock) begin
    if (we) begin wa_q.push_back(address); wd_q.push_back(out); end
    if (done) done_cnt++;
    if (we && !busy) we_idle++;
  end

  typedef struct packed {
    int n;
    logic [0:11][7:0] b;
    int bad;
    int nw;
    logic [0:3][15:0] wa;
    logic [0:3][7:0] wd;
    int ndone;
    logic err;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock) rx = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clock);
    end
    rx = stop;
    repeat (DIV) @(negedge clock);
    rx = 1'b1;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    vecs[0] = '{9, {8'hA5,8'h28,8'h00,8'h00,8'h03,8'h11,8'h22,8'h33,8'h00,8'h00,8'h00,8'h00}, -1, 3,
                {16'h2800,16'h2801,16'h2802,16'h0000}, {8'h11,8'h22,8'h33,8'h00}, 1, 1'b0};
    vecs[1] = '{9, {8'hA5,8'h28,8'h00,8'h00,8'h03,8'h11,8'h22,8'h33,8'h01,8'h00,8'h00,8'h00}, -1, 3,
                {16'h2800,16'h2801,16'h2802,16'h0000}, {8'h11,8'h22,8'h33,8'h00}, 0, 1'b1};
    vecs[2] = '{8, {8'hA5,8'hFF,8'hFF,8'h00,8'h02,8'hAA,8'hBB,8'h11,8'h00,8'h00,8'h00,8'h00}, -1, 2,
                {16'hFFFF,16'h0000,16'h0000,16'h0000}, {8'hAA,8'hBB,8'h00,8'h00}, 1, 1'b0};
    vecs[3] = '{6, {8'hA5,8'h00,8'h10,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, -1, 0,
                {16'h0000,16'h0000,16'h0000,16'h0000}, {8'h00,8'h00,8'h00,8'h00}, 1, 1'b0};
    vecs[4] = '{7, {8'hA5,8'h00,8'h20,8'h00,8'h03,8'h44,8'h55,8'h00,8'h00,8'h00,8'h00,8'h00}, 6, 1,
                {16'h0020,16'h0000,16'h0000,16'h0000}, {8'h44,8'h00,8'h00,8'h00}, 0, 1'b1};
    vecs[5] = '{7, {8'hA5,8'h01,8'h00,8'h00,8'h01,8'h5A,8'h5A,8'h00,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                {16'h0100,16'h0000,16'h0000,16'h0000}, {8'h5A,8'h00,8'h00,8'h00}, 1, 1'b0};
    vecs[6] = '{8, {8'hA5,8'h00,8'h30,8'h00,8'h02,8'hA5,8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00}, -1, 2,
                {16'h0030,16'h0031,16'h0000,16'h0000}, {8'hA5,8'hA5,8'h00,8'h00}, 1, 1'b0};

    repeat (4) @(negedge clock);
    chk("reset_outputs", {5'd0, address, out, we, busy, done, error}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("post_reset_outputs", {5'd0, address, out, we, busy, done, error}, 32'd0);

    for (int k = 0; k < 7; k++) begin
      clear_log();
      for (int i = 0; i < vecs[k].n; i++) begin
        send_byte(vecs[k].b[i], i != vecs[k].bad);
        if (i == 0) chk($sformatf("v%0d_busy_after_sync", k), {31'd0, busy}, 32'd1);
      end
      repeat (30) @(negedge clock);
      chk($sformatf("v%0d_nwrites", k), wa_q.size(), vecs[k].nw);
      for (int i = 0; i < vecs[k].nw; i++) begin
        chk($sformatf("v%0d_addr%0d", k, i), {16'd0, (i < wa_q.size()) ? wa_q[i] : 16'hxxxx}, {16'd0, vecs[k].wa[i]});
        chk($sformatf("v%0d_data%0d", k, i), {24'd0, (i < wd_q.size()) ? wd_q[i] : 8'hxx}, {24'd0, vecs[k].wd[i]});
      end
      chk($sformatf("v%0d_done", k), done_cnt, vecs[k].ndone);
      chk($sformatf("v%0d_error", k), {31'd0, error}, {31'd0, vecs[k].err});
      chk($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd0);
      if (vecs[k].err) begin
        send_byte(8'h11, 1'b1);
        repeat (10) @(negedge clock);
        chk($sformatf("v%0d_error_sticky", k), {31'd0, error}, 32'd1);
      end
    end

    // glitch between header bytes must not produce a byte
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b1);
    @(negedge clock) rx = 1'b0;
    @(negedge clock) rx = 1'b1;
    repeat (20) @(negedge clock);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h77, 1'b1);
    repeat (30) @(negedge clock);
    chk("glitch_nwrites", wa_q.size(), 1);
    chk("glitch_addr", {16'd0, (wa_q.size() > 0) ? wa_q[0] : 16'hxxxx}, 32'h0040);
    chk("glitch_done", done_cnt, 1);

    // timeout mid-packet
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (TIMEOUT - 200) @(negedge clock);
    chk("timeout_not_early", {31'd0, busy}, 32'd1);
    repeat (300) @(negedge clock);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk("timeout_error", {31'd0, error}, 32'd1);
    chk("timeout_nwrites", wa_q.size(), 1);
    chk("timeout_done", done_cnt, 0);

    // asynchronous reset mid-packet
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h33, 1'b1);
    chk("pre_reset_state", {8'd0, address, busy, error, 6'd0}, {8'd0, 16'h0050, 1'b1, 1'b0, 6'd0});
    @(negedge clock);
    #3 reset = 1'b1;
    #1 chk("async_reset_outputs", {5'd0, address, out, we, busy, done, error}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("we_while_idle", we_idle, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
